// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU definitions: operation encodings driven by the ALU control unit
// and the execute-stage FSM state type.
package alu_exec_stage_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } alu_sel_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ex_state_e;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_stage_core.sv
// Single-cycle combinational ALU. Shifts are computed here too, but the stage
// only uses that path when the shift amount is zero.
module alu_core
    import alu_exec_stage_pkg::*;
(
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    logic [SHW-1:0] shamt;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_sel)
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// EX stage: single-cycle ops through alu_core, non-zero shifts run bit-serially
// in the SHIFT state; registered output with valid/ready backpressure.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            reg_write_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [4:0]      rd_out,
    output logic            reg_write_out
);

    ex_state_e       state_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] work_q;
    logic [3:0]      shop_q;
    logic [4:0]      rd_hold_q;
    logic            rw_hold_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [4:0]      rd_out_q;
    logic            rw_out_q;

    logic [XLEN-1:0] core_res;
    logic [XLEN-1:0] work_d;
    logic [SHW-1:0]  shamt;
    logic            accept, start_shift, fast_load, shift_done;

    alu_core u_core (
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (core_res)
    );

    // rst_n is folded in so the stage advertises nothing while held in reset.
    assign in_ready    = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept      = in_valid && in_ready;
    assign shamt       = op_b[SHW-1:0];
    assign start_shift = accept && is_shift(alu_sel) && (shamt != '0);
    assign fast_load   = accept && !start_shift;
    assign shift_done  = (state_q == ST_SHIFT) && (cnt_q == SHW'(1));

    always_comb begin
        work_d = work_q >> 1;
        if (shop_q == ALU_SLL)
            work_d = work_q << 1;
        else if (shop_q == ALU_SRA)
            work_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            shop_q      <= '0;
            rd_hold_q   <= '0;
            rw_hold_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rd_out_q    <= '0;
            rw_out_q    <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_shift) begin
                    state_q   <= ST_SHIFT;
                    work_q    <= op_a;
                    cnt_q     <= shamt;
                    shop_q    <= alu_sel;
                    rd_hold_q <= rd_in;
                    rw_hold_q <= reg_write_in;
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (shift_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (fast_load) begin
                out_valid_q <= 1'b1;
                result_q    <= core_res;
                zero_q      <= (core_res == '0);
                rd_out_q    <= rd_in;
                rw_out_q    <= reg_write_in;
            end else if (shift_done) begin
                out_valid_q <= 1'b1;
                result_q    <= work_d;
                zero_q      <= (work_d == '0);
                rd_out_q    <= rd_hold_q;
                rw_out_q    <= rw_hold_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign rd_out        = rd_out_q;
    assign reg_write_out = rw_out_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        reg_write_in, flush;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd_out;
    logic        reg_write_out;

    int nvec = 0;
    int nmis = 0;

    alu_exec_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_sel       (alu_sel),
        .op_a          (op_a),
        .op_b          (op_b),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
        alu_sel = sel; op_a = a; op_b = b; rd_in = rd; reg_write_in = rw; in_valid = 1'b1;
        #1;
    endtask

    // Offer one op, check acceptance, then wait for out_valid and check all outputs.
    task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic rw,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        drive(sel, a, b, rd, rw);
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".res"}, result, exp);
        chk({tag, ".zero"}, 32'(zero), 32'(exp == 32'd0));
        chk({tag, ".rd"}, 32'(rd_out), 32'(rd));
        chk({tag, ".rw"}, 32'(reg_write_out), 32'(rw));
        step();
        chk({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; alu_sel = '0; op_a = '0; op_b = '0;
        rd_in = '0; reg_write_in = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.rd", 32'(rd_out), 32'd0);
        chk("rst.rw", 32'(reg_write_out), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rel.rdy", 32'(in_ready), 32'd1);

        run_op("add",   4'b0010, 32'd5,          32'd7,          5'd3,  1'b1, 32'd12,         1);
        run_op("sub",   4'b0110, 32'h1234,       32'h1234,       5'd4,  1'b1, 32'd0,          1);
        run_op("slt",   4'b1010, 32'hFFFF_FFFF,  32'd1,          5'd5,  1'b0, 32'd1,          1);
        run_op("sltu",  4'b1011, 32'hFFFF_FFFF,  32'd1,          5'd6,  1'b1, 32'd0,          1);
        run_op("and",   4'b0000, 32'hF0F0_1234,  32'h0FF0_FF00,  5'd7,  1'b1, 32'h00F0_1200,  1);
        run_op("or",    4'b0001, 32'hF000_0000,  32'h0000_000F,  5'd8,  1'b1, 32'hF000_000F,  1);
        run_op("xor",   4'b0100, 32'hFFFF_0000,  32'h0F0F_0F0F,  5'd9,  1'b1, 32'hF0F0_0F0F,  1);
        run_op("addwr", 4'b0010, 32'hFFFF_FFFF,  32'd1,          5'd10, 1'b1, 32'd0,          1);
        run_op("illeg", 4'b0011, 32'h1234_5678,  32'h0000_0001,  5'd11, 1'b1, 32'd0,          1);
        run_op("sll0",  4'b0111, 32'hDEAD_BEEF,  32'hFFFF_FFE0,  5'd12, 1'b1, 32'hDEAD_BEEF,  1);
        run_op("srl4",  4'b1000, 32'h8000_0000,  32'h0000_0024,  5'd13, 1'b1, 32'h0800_0000,  5);
        run_op("sll31", 4'b0111, 32'h0000_0003,  32'd31,         5'd14, 1'b1, 32'h8000_0000,  32);

        // SRA: in_ready held low for the four serial cycles.
        drive(4'b1001, 32'h8000_0000, 32'd4, 5'd15, 1'b1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sra.busy", 32'(in_ready), 32'd0);
            chk("sra.novld", 32'(out_valid), 32'd0);
            step();
        end
        chk("sra.vld", 32'(out_valid), 32'd1);
        chk("sra.res", result, 32'hF800_0000);
        chk("sra.rd", 32'(rd_out), 32'd15);
        step();

        // Backpressure: a held result blocks the next op until out_ready rises.
        out_ready = 1'b0;
        drive(4'b0010, 32'd1, 32'd2, 5'd20, 1'b1);
        step();
        chk("bp.vld1", 32'(out_valid), 32'd1);
        chk("bp.res1", result, 32'd3);
        drive(4'b0001, 32'h10, 32'h01, 5'd21, 1'b0);
        chk("bp.rdy0", 32'(in_ready), 32'd0);
        step(); step();
        chk("bp.hold", result, 32'd3);
        chk("bp.holdrd", 32'(rd_out), 32'd20);
        chk("bp.holdv", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp.rdy1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp.vld2", 32'(out_valid), 32'd1);
        chk("bp.res2", result, 32'h11);
        chk("bp.rd2", 32'(rd_out), 32'd21);
        chk("bp.rw2", 32'(reg_write_out), 32'd0);
        step();
        chk("bp.drain", 32'(out_valid), 32'd0);

        // Flush during the third serial cycle of SLL by 10.
        drive(4'b0111, 32'd1, 32'd10, 5'd22, 1'b1);
        step();
        in_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        #1;
        chk("fl.rdy0", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl.rdy1", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("fl.noout", 32'(seen), 32'd0);

        // Reset pulse mid SRL by 31.
        drive(4'b1000, 32'hFFFF_FFFF, 32'd31, 5'd23, 1'b1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr.vld", 32'(out_valid), 32'd0);
        chk("mr.res", result, 32'd0);
        chk("mr.rd", 32'(rd_out), 32'd0);
        chk("mr.rw", 32'(reg_write_out), 32'd0);
        chk("mr.rdy", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mr.rel", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("mr.noout", 32'(seen), 32'd0);

        run_op("post", 4'b0010, 32'd100, 32'd23, 5'd31, 1'b1, 32'd123, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
